boxcar_decim_16x: RTL and testbench

//  Integrate-and-dump decimator: averages 16 consecutive 3.2MHz samples into one 200kHz sample.

---
 rtl/decim_pkg.sv | 12 +
 rtl/boxcar_decim_16x_if.sv | 18 +
 rtl/decim_phase_ctr.sv | 27 ++
 rtl/boxcar_decim_16x.sv | 78 +++++++
 tb/tb_boxcar_decim_16x.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decim_pkg.sv
// Shared widths and sample/accumulator types for the 16x boxcar decimator.
package decim_pkg;

  localparam int DECIM_LOG2R = 4;
  localparam int DECIM_R     = 1 << DECIM_LOG2R;
  localparam int SAMPLE_W    = 16;
  localparam int ACC_W       = SAMPLE_W + DECIM_LOG2R;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/boxcar_decim_16x_if.sv
// Sample bus of the boxcar decimator: 3.2MHz input plus sync, 200kHz output with strobe and phase.
interface boxcar_decim_16x_if
  import decim_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int LOG2R = DECIM_LOG2R
);

  logic signed [DW-1:0] din;
  logic                 sync;
  logic signed [DW-1:0] dout;
  logic                 en_200k_out;
  logic [LOG2R-1:0]     phase;

  modport master (output din, sync, input dout, en_200k_out, phase);
  modport slave  (input din, sync, output dout, en_200k_out, phase);

endinterface

// File: rtl/decim_phase_ctr.sv
// Frame phase counter: wraps every R samples, sync reloads it to 1; tc marks the dump edge.
module decim_phase_ctr
  import decim_pkg::*;
#(
  parameter int LOG2R = DECIM_LOG2R
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  output logic [LOG2R-1:0] phase,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (sync) begin
      phase <= LOG2R'(1);
    end else begin
      phase <= phase + LOG2R'(1);
    end
  end

  // sync outranks the dump, so a restart at the last phase never produces a pulse
  assign tc = (phase == '1) && !sync;

endmodule

// File: rtl/boxcar_decim_16x.sv
// Integrate-and-dump decimator: averages R=2**LOG2R input samples into one output sample.
// Define DECIM_ROUND_EN for round-half-up with saturation instead of floor.
module boxcar_decim_16x
  import decim_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int LOG2R = DECIM_LOG2R
) (
  input  logic               clk,
  input  logic               rst_n,
  boxcar_decim_16x_if.slave  bus
);

  localparam int AW = DW + LOG2R;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] dump_val;
  logic signed [DW-1:0] dout;
  logic                 en_200k_out;
  logic [LOG2R-1:0]     phase;
  logic                 tc;

  decim_phase_ctr #(.LOG2R(LOG2R)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (bus.sync),
    .phase (phase),
    .tc    (tc)
  );

  always_comb sum = acc + AW'(bus.din);

`ifdef DECIM_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (LOG2R - 1));
  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (DW - 1)));

  logic signed [AW-1:0] scaled;

  // sum+HALF stays within AW bits: |sum| <= R*2**(DW-1) and HALF is tiny
  always_comb begin
    scaled = (sum + HALF) >>> LOG2R;
    if (scaled > SMAX) begin
      dump_val = SMAX[DW-1:0];
    end else if (scaled < SMIN) begin
      dump_val = SMIN[DW-1:0];
    end else begin
      dump_val = scaled[DW-1:0];
    end
  end
`else
  always_comb dump_val = DW'(sum >>> LOG2R);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      dout        <= '0;
      en_200k_out <= 1'b0;
    end else if (bus.sync) begin
      acc         <= AW'(bus.din);
      en_200k_out <= 1'b0;
    end else if (tc) begin
      acc         <= '0;
      dout        <= dump_val;
      en_200k_out <= 1'b1;
    end else begin
      acc         <= sum;
      en_200k_out <= 1'b0;
    end
  end

  assign bus.dout        = dout;
  assign bus.en_200k_out = en_200k_out;
  assign bus.phase       = phase;

endmodule

// File: tb/tb_boxcar_decim_16x.sv
// Self-checking bench for boxcar_decim_16x: behavioural model feeds a scoreboard of expected dumps.
module tb_boxcar_decim_16x;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  boxcar_decim_16x_if #(.DW(16), .LOG2R(4)) bus ();

  boxcar_decim_16x #(.DW(16), .LOG2R(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic signed [15:0] exp_q[$];
  longint             m_acc   = 0;
  int                 m_phase = 0;
  logic               m_en    = 1'b0;
  logic signed [15:0] m_dout  = '0;
  logic               mon_on  = 1'b0;

  function automatic logic signed [15:0] avg16(input longint s);
    longint q;
    longint t;
    t = s;
`ifdef DECIM_ROUND_EN
    t = t + 8;
`endif
    q = t / 16;
    if ((t % 16) != 0 && t < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic model_reset();
    m_acc   = 0;
    m_phase = 0;
    m_en    = 1'b0;
    m_dout  = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model tracks the edge and queues each expected dump.
  task automatic step(input logic signed [15:0] d, input logic s);
    bus.din  = d;
    bus.sync = s;
    @(posedge clk);
    if (s) begin
      m_acc   = longint'(d);
      m_phase = 1;
      m_en    = 1'b0;
    end else if (m_phase == 15) begin
      m_dout  = avg16(m_acc + longint'(d));
      exp_q.push_back(m_dout);
      m_acc   = 0;
      m_phase = 0;
      m_en    = 1'b1;
    end else begin
      m_acc   = m_acc + longint'(d);
      m_phase = m_phase + 1;
      m_en    = 1'b0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      compared++;
      if (bus.en_200k_out !== m_en) begin
        mismatched++;
        $display("FAIL strobe: got %b expected %b at %0t", bus.en_200k_out, m_en, $time);
      end
      compared++;
      if (bus.phase !== 4'(m_phase)) begin
        mismatched++;
        $display("FAIL phase: got %0d expected %0d at %0t", bus.phase, m_phase, $time);
      end
      if (m_en) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard_empty: got dout %0d expected a queued value at %0t", bus.dout, $time);
        end else begin
          logic signed [15:0] e;
          e = exp_q.pop_front();
          if (bus.dout !== e) begin
            mismatched++;
            $display("FAIL dout: got %0d expected %0d at %0t", bus.dout, e, $time);
          end
        end
      end else begin
        compared++;
        if (bus.dout !== m_dout) begin
          mismatched++;
          $display("FAIL dout_hold: got %0d expected %0d at %0t", bus.dout, m_dout, $time);
        end
      end
    end
  end

  task automatic test_reset();
    int first;
    int last;
    bus.din  = '0;
    bus.sync = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (bus.dout !== 16'sd0 || bus.en_200k_out !== 1'b0 || bus.phase !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_state: got dout=%0d en=%b phase=%0d expected 0/0/0",
               bus.dout, bus.en_200k_out, bus.phase);
    end
    rst_n  = 1'b1;
    mon_on = 1'b1;
    first  = -1;
    last   = -1;
    for (int i = 1; i <= 64; i++) begin
      step(16'sd1000, 1'b0);
      if (bus.en_200k_out === 1'b1) begin
        if (first < 0) begin
          first = i;
        end else begin
          compared++;
          if (i - last != 16) begin
            mismatched++;
            $display("FAIL pulse_period: got %0d expected 16", i - last);
          end
        end
        last = i;
      end
    end
    compared++;
    if (first != 16) begin
      mismatched++;
      $display("FAIL first_pulse: got edge %0d expected edge 16", first);
    end
    compared++;
    if (bus.dout !== 16'sd1000) begin
      mismatched++;
      $display("FAIL const_1000: got %0d expected 1000", bus.dout);
    end
  endtask

  task automatic test_ramp();
    logic signed [15:0] want;
`ifdef DECIM_ROUND_EN
    want = 16'sd8;
`else
    want = 16'sd7;
`endif
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        step(16'(k), (f == 0 && k == 0));
      end
    end
    compared++;
    if (bus.dout !== want) begin
      mismatched++;
      $display("FAIL ramp_avg: got %0d expected %0d", bus.dout, want);
    end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 32; k++) step(16'sd32767, (k == 0));
    compared++;
    if (bus.dout !== 16'sd32767) begin
      mismatched++;
      $display("FAIL max_input: got %0d expected 32767", bus.dout);
    end
    for (int k = 0; k < 32; k++) step(-16'sd32768, (k == 0));
    compared++;
    if (bus.dout !== -16'sd32768) begin
      mismatched++;
      $display("FAIL min_input: got %0d expected -32768", bus.dout);
    end
  endtask

  task automatic test_sync_restart();
    int pulse_at;
    logic signed [15:0] held;
    step(16'sd300, 1'b1);
    for (int k = 0; k < 4; k++) step(16'sd300, 1'b0);
    step(16'sd50, 1'b1);
    pulse_at = -1;
    for (int i = 1; i <= 16; i++) begin
      step(16'sd50, 1'b0);
      if (bus.en_200k_out === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    compared++;
    if (pulse_at != 15) begin
      mismatched++;
      $display("FAIL sync_mid_pulse: got edge %0d expected edge 16 after sync", pulse_at + 1);
    end
    step(16'sd200, 1'b1);
    for (int k = 0; k < 14; k++) step(16'sd200, 1'b0);
    held = bus.dout;
    step(16'sd200, 1'b1);
    compared++;
    if (bus.en_200k_out !== 1'b0 || bus.dout !== held) begin
      mismatched++;
      $display("FAIL sync_last_phase: got en=%b dout=%0d expected en=0 dout=%0d",
               bus.en_200k_out, bus.dout, held);
    end
    for (int k = 0; k < 15; k++) step(16'sd200, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int first;
    step(16'sd500, 1'b1);
    for (int k = 0; k < 15; k++) step(16'sd500, 1'b0);
    for (int k = 0; k < 9; k++) step(-16'sd900, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (bus.dout !== 16'sd0 || bus.en_200k_out !== 1'b0 || bus.phase !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got dout=%0d en=%b phase=%0d expected 0/0/0",
               bus.dout, bus.en_200k_out, bus.phase);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step(16'sd77, 1'b0);
      if (bus.en_200k_out === 1'b1 && first < 0) first = i;
    end
    compared++;
    if (first != 16) begin
      mismatched++;
      $display("FAIL reset_release_pulse: got edge %0d expected edge 16", first);
    end
    for (int k = 0; k < 12; k++) step(16'sd77, 1'b0);
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 48; k++) begin
      step((k % 2 == 0) ? 16'sd16 : -16'sd16, (k == 0));
      if (bus.en_200k_out === 1'b1) begin
        compared++;
        if (bus.dout !== 16'sd0) begin
          mismatched++;
          $display("FAIL alternating: got %0d expected 0", bus.dout);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2000; f++) begin
      for (int k = 0; k < 16; k++) begin
        step(16'($urandom), ($urandom_range(0, 299) == 0));
      end
    end
    step(16'sd0, 1'b1);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_extremes();
    test_sync_restart();
    test_reset_mid_frame();
    test_alternating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
